instr_encoder_loader: RTL and testbench

//  Inverse of the instruction decoder: accepts symbolic instructions (mnemonic + fields) over valid/ready,

---
 rtl/instr_encoder_loader.sv | 249 ++++++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Boot/program loader: accepts symbolic MIPS instructions (mnemonic + fields)
// over a valid/ready handshake, encodes each into a 32-bit MIPS word and
// writes it sequentially into instruction memory starting at START_ADDR.
//
// Parameters
//   IMEM_AWIDTH  imem word-address width (DEPTH = 2**IMEM_AWIDTH words)
//   START_ADDR   first word address written after reset/start
//
// Ports
//   clk         clock, all state on rising edge
//   reset_n     synchronous active-low reset
//   in_valid    instruction fields valid
//   in_ready    loader can accept a new instruction (IDLE)
//   in_last     final instruction of the program
//   mnem        mnemonic code 0..27 (28..31 illegal)
//   rs/rt/rd    register fields
//   shamt       shift amount
//   imm         I-type immediate / branch offset
//   target      J-type word target
//   start       restart from DONE/ERR
//   imem_we     imem write request
//   imem_ready  imem accepts the write this cycle
//   imem_addr   imem word address
//   imem_wdata  encoded instruction word
//   count       words committed since reset/start
//   done        program loaded
//   err_code    00 none, 01 illegal mnemonic, 10 address overflow
//   checksum    XOR of committed words (only when INSTR_LOADER_CHECKSUM_EN
//               is defined, otherwise constant zero)
//
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int          IMEM_AWIDTH = 10,
    parameter int unsigned START_ADDR  = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [4:0]             mnem,
    input  logic [4:0]             rs,
    input  logic [4:0]             rt,
    input  logic [4:0]             rd,
    input  logic [4:0]             shamt,
    input  logic [15:0]            imm,
    input  logic [25:0]            target,
    input  logic                   start,
    output logic                   imem_we,
    input  logic                   imem_ready,
    output logic [IMEM_AWIDTH-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic [IMEM_AWIDTH:0]   count,
    output logic                   done,
    output logic [1:0]             err_code,
    output logic [31:0]            checksum
);

    localparam logic [IMEM_AWIDTH-1:0] START_A  = IMEM_AWIDTH'(START_ADDR);
    localparam logic [IMEM_AWIDTH-1:0] ADDR_MAX = {IMEM_AWIDTH{1'b1}};
    localparam logic [IMEM_AWIDTH-1:0] ADDR_ONE = {{(IMEM_AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [IMEM_AWIDTH:0]   CNT_ONE  = {{IMEM_AWIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // Encode one symbolic instruction; fields that the format does not use
    // are forced to zero so stray input bits never leak into the word.
    function automatic logic [31:0] encode(
        input logic [4:0]  mn,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_sh,
        input logic [15:0] f_imm,
        input logic [25:0] f_tgt
    );
        logic [31:0] w;
        w = 32'h0;
        case (mn)
            5'd0:    w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h20}; // ADD
            5'd1:    w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h21}; // ADDU
            5'd2:    w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h22}; // SUB
            5'd3:    w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h24}; // AND
            5'd4:    w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h25}; // OR
            5'd5:    w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h26}; // XOR
            5'd6:    w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h27}; // NOR
            5'd7:    w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h2A}; // SLT
            5'd8:    w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h2B}; // SLTU
            5'd9:    w = {6'h00, 5'd0, f_rt, f_rd, f_sh, 6'h00}; // SLL
            5'd10:   w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h04}; // SLLV
            5'd11:   w = {6'h00, 5'd0, f_rt, f_rd, f_sh, 6'h02}; // SRL
            5'd12:   w = {6'h00, 5'd0, f_rt, f_rd, f_sh, 6'h03}; // SRA
            5'd13:   w = {6'h00, f_rs, 15'd0, 6'h08};            // JR
            5'd14:   w = {6'h23, f_rs, f_rt, f_imm};             // LW
            5'd15:   w = {6'h2B, f_rs, f_rt, f_imm};             // SW
            5'd16:   w = {6'h08, f_rs, f_rt, f_imm};             // ADDI
            5'd17:   w = {6'h09, f_rs, f_rt, f_imm};             // ADDIU
            5'd18:   w = {6'h0A, f_rs, f_rt, f_imm};             // SLTI
            5'd19:   w = {6'h0B, f_rs, f_rt, f_imm};             // SLTIU
            5'd20:   w = {6'h0D, f_rs, f_rt, f_imm};             // ORI
            5'd21:   w = {6'h0F, 5'd0, f_rt, f_imm};             // LUI
            5'd22:   w = {6'h0C, f_rs, f_rt, f_imm};             // ANDI
            5'd23:   w = {6'h0E, f_rs, f_rt, f_imm};             // XORI
            5'd24:   w = {6'h04, f_rs, f_rt, f_imm};             // BEQ
            5'd25:   w = {6'h05, f_rs, f_rt, f_imm};             // BNE
            5'd26:   w = {6'h02, f_tgt};                         // J
            5'd27:   w = {6'h03, f_tgt};                         // JAL
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    state_t                 state_q, state_d;
    logic [IMEM_AWIDTH-1:0] addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   last_q, last_d;
    logic [IMEM_AWIDTH:0]   count_q, count_d;
    logic [1:0]             err_q, err_d;
    logic                   rdy_q, we_q, done_q;
    logic                   illegal_s;
    logic                   commit_s;
    logic                   restart_s;

    assign illegal_s = (mnem >= 5'd28);
    assign commit_s  = (state_q == S_WRITE) && imem_ready;
    assign restart_s = ((state_q == S_DONE) || (state_q == S_ERR)) && start;

    // Next-state and datapath update for the load sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (illegal_s) begin
                        state_d = S_ERR;
                        err_d   = 2'b01;
                    end else begin
                        state_d = S_WRITE;
                        wdata_d = encode(mnem, rs, rt, rd, shamt, imm, target);
                        last_d  = in_last;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (commit_s) begin
                    count_d = count_q + CNT_ONE;
                    // Overflow is checked before the increment so the
                    // address can never wrap back onto loaded words.
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (addr_q == ADDR_MAX) begin
                        state_d = S_ERR;
                        err_d   = 2'b10;
                    end else begin
                        state_d = S_IDLE;
                        addr_d  = addr_q + ADDR_ONE;
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE, S_ERR: begin
                if (restart_s) begin
                    state_d = S_IDLE;
                    addr_d  = START_A;
                    count_d = {(IMEM_AWIDTH+1){1'b0}};
                    err_d   = 2'b00;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake/status outputs are registered
    // from the next state so they are glitch-free and aligned with it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= START_A;
            wdata_q <= 32'h0;
            last_q  <= 1'b0;
            count_q <= {(IMEM_AWIDTH+1){1'b0}};
            err_q   <= 2'b00;
            rdy_q   <= 1'b1;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            count_q <= count_d;
            err_q   <= err_d;
            rdy_q   <= (state_d == S_IDLE);
            we_q    <= (state_d == S_WRITE);
            done_q  <= (state_d == S_DONE);
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;

    // Running XOR of every committed word, cleared on reset and restart.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csum_q <= 32'h0;
        end else if (restart_s) begin
            csum_q <= 32'h0;
        end else if (commit_s) begin
            csum_q <= csum_q ^ wdata_q;
        end else begin
            csum_q <= csum_q;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 32'h0;
`endif

    assign in_ready   = rdy_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// Testbench for instr_encoder_loader (IMEM_AWIDTH=2 so overflow is reachable).
// A protocol-level reference model tracks what the loader must show; a
// negedge process compares every output against it, and directed tests add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [4:0]    mnem, rs, rt, rd, shamt;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          start;
    logic          imem_we;
    logic          imem_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic [1:0]    err_code;
    logic [31:0]   checksum;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    instr_encoder_loader #(.IMEM_AWIDTH(AW), .START_ADDR(0)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target), .start(start), .imem_we(imem_we),
        .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .done(done), .err_code(err_code), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Instruction format class per mnemonic:
    // 0 R-type, 1 R-type constant shift, 2 JR, 3 I-type, 4 LUI, 5 J-type
    int kind_t [28] = '{0,0,0,0,0,0,0,0,0,1,0,1,1,2,3,3,3,3,3,3,3,4,3,3,3,3,5,5};
    // funct for R-types, opcode for I/J-types
    int code_t [28] = '{32,33,34,36,37,38,39,42,43,0,4,2,3,8,35,43,8,9,10,11,13,15,12,14,4,5,2,3};

    function automatic logic [31:0] m_enc(input int mn, input int f_rs, input int f_rt,
                                          input int f_rd, input int f_sh, input int f_imm,
                                          input int f_tg);
        int c;
        if (mn >= 28) return 32'h0;
        c = code_t[mn];
        case (kind_t[mn])
            0: return 32'((f_rs << 21) | (f_rt << 16) | (f_rd << 11) | c);
            1: return 32'((f_rt << 16) | (f_rd << 11) | (f_sh << 6) | c);
            2: return 32'((f_rs << 21) | 8);
            3: return 32'((c << 26) | (f_rs << 21) | (f_rt << 16) | f_imm);
            4: return 32'((c << 26) | (f_rt << 16) | f_imm);
            5: return 32'((c << 26) | f_tg);
            default: return 32'h0;
        endcase
    endfunction

    // Reference model state
    bit          m_pend = 1'b0;
    bit          m_last = 1'b0;
    bit          m_done = 1'b0;
    int          m_addr = 0;
    int          m_count = 0;
    int          m_err = 0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_csum = 32'h0;

    // Reference model: advances on each rising edge from the DUT's inputs only.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_pend <= 1'b0; m_done <= 1'b0; m_addr <= 0; m_count <= 0;
            m_err <= 0; m_csum <= 32'h0;
        end else if (m_done || m_err != 0) begin
            if (start) begin
                m_done <= 1'b0; m_err <= 0; m_addr <= 0; m_count <= 0; m_csum <= 32'h0;
            end
        end else if (m_pend) begin
            if (imem_ready) begin
                m_pend  <= 1'b0;
                m_count <= m_count + 1;
                m_csum  <= m_csum ^ m_wdata;
                if (m_last) m_done <= 1'b1;
                else if (m_addr == DEPTH - 1) m_err <= 2;
                else m_addr <= m_addr + 1;
            end
        end else if (in_valid) begin
            if (int'(mnem) >= 28) m_err <= 1;
            else begin
                m_pend  <= 1'b1;
                m_last  <= in_last;
                m_wdata <= m_enc(int'(mnem), int'(rs), int'(rt), int'(rd), int'(shamt),
                                 int'(imm), int'(target));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_csum(input logic [31:0] v);
`ifdef INSTR_LOADER_CHECKSUM_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_in_ready", 32'(in_ready), 32'(!m_pend && !m_done && m_err == 0));
            check("m_imem_we",  32'(imem_we),  32'(m_pend));
            check("m_addr",     32'(imem_addr), 32'(m_addr));
            check("m_count",    32'(count),    32'(m_count));
            check("m_done",     32'(done),     32'(m_done));
            check("m_err",      32'(err_code), 32'(m_err));
            check("m_checksum", checksum,      exp_csum(m_csum));
            if (m_pend) check("m_wdata", imem_wdata, m_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int mn, input int f_rs, input int f_rt, input int f_rd,
                        input int f_sh, input int f_imm, input int f_tg, input bit last);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("send_ready_timeout", 32'(in_ready), 32'h1);
        end else begin
            mnem = 5'(mn); rs = 5'(f_rs); rt = 5'(f_rt); rd = 5'(f_rd);
            shamt = 5'(f_sh); imm = 16'(f_imm); target = 26'(f_tg);
            in_last = last; in_valid = 1'b1;
            tick();
            in_valid = 1'b0; in_last = 1'b0;
        end
    endtask

    task automatic restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_count", 32'(count), 32'h0);
        check("restart_err", 32'(err_code), 32'h0);
        check("restart_ready", 32'(in_ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        imem_ready = 1'b1; mnem = 5'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0;
        shamt = 5'd0; imm = 16'h0; target = 26'h0;
        tick(); tick();

        // Reset state
        check("rst_ready", 32'(in_ready), 32'h1);
        check("rst_we", 32'(imem_we), 32'h0);
        check("rst_addr", 32'(imem_addr), 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err_code), 32'h0);
        check("rst_csum", checksum, 32'h0);
        chk_en = 1'b1;
        reset_n = 1'b1;
        tick();

        // Model pins against hand-encoded words
        check("pin_add",  m_enc(0, 1, 2, 3, 0, 0, 0),          32'h00221820);
        check("pin_addi", m_enc(16, 0, 8, 0, 0, 16'hFFFF, 0),  32'h2008FFFF);
        check("pin_sll",  m_enc(9, 7, 1, 2, 4, 0, 0),          32'h00011100);
        check("pin_j",    m_enc(26, 0, 0, 0, 0, 0, 26'h0100000), 32'h08100000);
        check("pin_jr",   m_enc(13, 31, 5, 6, 7, 0, 0),        32'h03E00008);
        check("pin_lui",  m_enc(21, 9, 10, 0, 0, 16'h1234, 0), 32'h3C0A1234);

        // Single ADD with last: write visible the cycle after acceptance
        send(0, 1, 2, 3, 0, 0, 0, 1'b1);
        check("add_we", 32'(imem_we), 32'h1);
        check("add_addr", 32'(imem_addr), 32'h0);
        check("add_wdata", imem_wdata, 32'h00221820);
        check("add_ready", 32'(in_ready), 32'h0);
        tick();
        check("add_done", 32'(done), 32'h1);
        check("add_count", 32'(count), 32'h1);
        check("add_csum", checksum, exp_csum(32'h00221820));
        tick();
        check("done_hold", 32'(done), 32'h1);
        restart();

        // ADDI, SLL (stalled 3 cycles), J last; checksum of the three
        send(16, 0, 8, 0, 0, 16'hFFFF, 0, 1'b0);
        send(9, 7, 1, 2, 4, 0, 0, 1'b0);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_we", 32'(imem_we), 32'h1);
            check("stall_wdata", imem_wdata, 32'h00011100);
            check("stall_addr", 32'(imem_addr), 32'h1);
            check("stall_count", 32'(count), 32'h1);
            check("stall_ready", 32'(in_ready), 32'h0);
        end
        imem_ready = 1'b1;
        tick();
        check("stall_commit", 32'(count), 32'h2);
        send(26, 0, 0, 0, 0, 0, 26'h0100000, 1'b1);
        check("j_wdata", imem_wdata, 32'h08100000);
        tick();
        check("prog3_done", 32'(done), 32'h1);
        check("prog3_count", 32'(count), 32'h3);
        check("prog3_csum", checksum, exp_csum(32'h2819EEFF));
        restart();

        // Illegal mnemonic
        send(30, 1, 2, 3, 4, 5, 6, 1'b0);
        check("ill_err", 32'(err_code), 32'h1);
        check("ill_we", 32'(imem_we), 32'h0);
        check("ill_ready", 32'(in_ready), 32'h0);
        tick();
        check("ill_hold", 32'(err_code), 32'h1);
        restart();

        // Field-forcing table, two 4-word programs
        send(2, 3, 4, 5, 9, 0, 0, 1'b0);               // SUB, shamt dropped
        send(13, 31, 5, 6, 7, 0, 0, 1'b0);             // JR
        send(21, 9, 10, 0, 0, 16'h1234, 0, 1'b0);      // LUI
        send(15, 29, 31, 0, 0, 16'hFFFC, 0, 1'b1);     // SW last at addr 3
        tick();
        check("tbl1_done", 32'(done), 32'h1);
        restart();
        send(25, 1, 2, 0, 0, 16'h8000, 0, 1'b0);       // BNE
        send(27, 0, 0, 0, 0, 0, 26'h3FFFFFF, 1'b0);    // JAL
        send(12, 5, 6, 7, 31, 0, 0, 1'b0);             // SRA, rs dropped
        send(10, 1, 2, 3, 5, 0, 0, 1'b1);              // SLLV
        tick();
        check("tbl2_done", 32'(done), 32'h1);
        restart();

        // Overflow: 4 words without last fill memory, then ERR
        for (int i = 0; i < 4; i++) send(4, i, i + 1, i + 2, 0, 0, 0, 1'b0);
        tick();
        check("ovf_err", 32'(err_code), 32'h2);
        check("ovf_count", 32'(count), 32'h4);
        check("ovf_addr", 32'(imem_addr), 32'h3);
        mnem = 5'd0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ovf_no_we", 32'(imem_we), 32'h0);
        end
        in_valid = 1'b0;
        check("ovf_count_hold", 32'(count), 32'h4);
        restart();

        // Reset during a stalled write
        for (int i = 0; i < 3; i++) send(17, i, 7, 0, 0, 16'h0100 + i, 0, 1'b0);
        send(20, 3, 4, 0, 0, 16'hABCD, 0, 1'b0);
        imem_ready = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        check("rstw_we", 32'(imem_we), 32'h0);
        check("rstw_addr", 32'(imem_addr), 32'h0);
        check("rstw_count", 32'(count), 32'h0);
        reset_n = 1'b1;
        imem_ready = 1'b1;
        tick(); tick();
        check("rstw_ready", 32'(in_ready), 32'h1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
